// File: rtl/uart_rx.sv
// Oversampling UART receiver: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit.
// The start bit is checked at its middle; each later bit is sampled one bit period after that.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_nxt;
  logic                  rx_meta, rx_s, rx_s_d;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_BITS-1:0]  shreg;
  logic                  wrap, sample_pt;

  // Synchronizer preset high so a released reset does not look like a start edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // START waits half a bit to reach mid start bit; later states wait a full bit.
  assign wrap      = (state == START) ? (tick_cnt == HALF_M1) : (tick_cnt == FULL_M1);
  assign sample_pt = sample_tick && wrap;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (rx_s_d && !rx_s) state_nxt = START;
      START: if (sample_pt) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (sample_pt && bit_cnt == LAST_BIT) state_nxt = STOP;
      STOP:  if (sample_pt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      if (state == IDLE) begin
        tick_cnt <= '0;
      end else if (sample_tick) begin
        tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
      end
      if (sample_pt) begin
        case (state)
          START: bit_cnt <= '0;
          DATA: begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
          end
          STOP: begin
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
